// File: rtl/conv_pkg.sv
// Shared definitions for the conv2d layer scheduler: FSM state codes,
// buffer size / address width helpers and the default watchdog limit.
package conv_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam int DEFAULT_TIMEOUT_CYC = 4096;

    function automatic int calcInSize(input int w, input int h, input int ch);
        return w * h * ch;
    endfunction

    function automatic int calcOutSize(input int w, input int h, input int ch);
        return w * h * ch;
    endfunction

    // Degenerate one-entry buffers still need a one-bit address bus.
    function automatic int addrWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_sched_wdt.sv
// Drain watchdog: counts idle cycles while enabled and flags the cycle on
// which the count would reach TIMEOUT_CYC.
module conv_sched_wdt
    import conv_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CW'(TIMEOUT_CYC))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry is flagged one cycle early so the owner changes state on the
    // same edge the count reaches the limit.
    assign o_expired = i_en && !i_clr && (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/conv_layer_sched.sv
// Runs one conv2d layer pass: feeds the input buffer into the engine, then
// writes every engine result to the output buffer. CONV_SCHED_RELU_EN fuses ReLU on writeback.
module conv_layer_sched
    import conv_pkg::*;
#(
    parameter  int IMG_WIDTH   = 28,
    parameter  int IMG_HEIGHT  = 28,
    parameter  int IN_CHANNEL  = 1,
    parameter  int OUT_CHANNEL = 8,
    parameter  int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    localparam int IN_SIZE     = calcInSize(IMG_WIDTH, IMG_HEIGHT, IN_CHANNEL),
    localparam int OUT_SIZE    = calcOutSize(IMG_WIDTH, IMG_HEIGHT, OUT_CHANNEL),
    localparam int IA_W        = addrWidth(IN_SIZE),
    localparam int OA_W        = addrWidth(OUT_SIZE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            ibuf_rd_en,
    output logic [IA_W-1:0] ibuf_rd_addr,
    input  logic [7:0]      ibuf_rd_data,
    output logic            eng_in_valid,
    output logic [7:0]      eng_in_data,
    input  logic            eng_out_valid,
    input  logic [31:0]     eng_out_data,
    output logic            obuf_wr_en,
    output logic [OA_W-1:0] obuf_wr_addr,
    output logic [31:0]     obuf_wr_data
);

    localparam logic [IA_W-1:0] IN_LAST  = IA_W'(IN_SIZE - 1);
    localparam logic [OA_W-1:0] OUT_LAST = OA_W'(OUT_SIZE - 1);

    logic [2:0]      r_state;
    logic [IA_W-1:0] r_in_cnt;
    logic [OA_W-1:0] r_out_cnt;
    logic            r_out_full;
    logic            r_err;
    logic            r_wr_en;
    logic [OA_W-1:0] r_wr_addr;
    logic [31:0]     r_wr_data;

    logic            w_last_beat;
    logic            w_accept;
    logic            w_wdt_clr;
    logic            w_wdt_exp;
    logic [31:0]     w_wb_data;

    assign w_last_beat = (r_state == S_FEED) && (r_in_cnt == IN_LAST);
    // r_out_full blocks extra strobes after the final result so out_cnt never wraps.
    assign w_accept    = (r_state == S_DRAIN) && eng_out_valid && !r_out_full && !abort;
    assign w_wdt_clr   = (r_state != S_DRAIN) || eng_out_valid || abort;

`ifdef CONV_SCHED_RELU_EN
    assign w_wb_data = eng_out_data[31] ? 32'd0 : eng_out_data;
`else
    assign w_wb_data = eng_out_data;
`endif

    conv_sched_wdt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_wdt_clr),
        .i_en      (r_state == S_DRAIN),
        .o_expired (w_wdt_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_out_full <= 1'b0;
            r_err      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else if (abort) begin
            r_state    <= S_IDLE;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_out_full <= 1'b0;
            r_err      <= 1'b0;
            r_wr_en    <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= r_out_cnt;
                r_wr_data <= w_wb_data;
                if (r_out_cnt == OUT_LAST) begin
                    r_out_full <= 1'b1;
                end else begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_ARM;
                        r_err      <= 1'b0;
                        r_in_cnt   <= '0;
                        r_out_cnt  <= '0;
                        r_out_full <= 1'b0;
                    end
                end
                S_ARM: begin
                    r_state  <= S_FEED;
                    r_in_cnt <= '0;
                end
                S_FEED: begin
                    if (w_last_beat) begin
                        r_state  <= S_DRAIN;
                        r_in_cnt <= '0;
                    end else begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Finish only once the final write is on the bus, so done trails it by one cycle.
                    if (w_wdt_exp) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end else if (r_wr_en && (r_wr_addr == OUT_LAST)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (r_state == S_ARM) || (r_state == S_FEED) || (r_state == S_DRAIN);
    assign done         = (r_state == S_DONE);
    assign err          = r_err;
    assign ibuf_rd_en   = (r_state == S_ARM) || ((r_state == S_FEED) && !w_last_beat);
    assign ibuf_rd_addr = ((r_state == S_FEED) && !w_last_beat) ? (r_in_cnt + 1'b1) : '0;
    assign eng_in_valid = (r_state == S_ARM) || (r_state == S_FEED);
    assign eng_in_data  = (r_state == S_FEED) ? ibuf_rd_data : 8'd0;
    assign obuf_wr_en   = r_wr_en;
    assign obuf_wr_addr = r_wr_addr;
    assign obuf_wr_data = r_wr_data;

endmodule
